// File: rtl/vga_timing_pkg.sv
// Shared VGA raster geometry, sync windows and screen layout constants.
// Pure constants and types; no latency and no backpressure.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Screen layout used by the color generator, kept here so both blocks agree.
  localparam int FRAME_LEFT   = 150;
  localparam int FRAME_RIGHT  = 490;
  localparam int FRAME_TOP    = 70;
  localparam int FRAME_BOTTOM = 410;
  localparam int BOARD_LEFT   = 160;
  localparam int BOARD_RIGHT  = 480;
  localparam int BOARD_TOP    = 80;
  localparam int BOARD_BOTTOM = 400;

  typedef logic [9:0] cnt_t;
  typedef logic [8:0] row_t;
  typedef logic [9:0] col_t;

  function automatic logic in_span(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Pixel-timing bundle from the raster generator to the color generator.
// Plain wires; no latency and no backpressure.
interface vga_timing_generator_if;
  import vga_timing_pkg::*;

  logic hsync;
  logic vsync;
  logic blank_n;
  row_t row;
  col_t column;
  logic pixel_tick;
  logic frame_start;

  modport master (
    output hsync, vsync, blank_n, row, column, pixel_tick, frame_start
  );

  modport slave (
    input hsync, vsync, blank_n, row, column, pixel_tick, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter for one raster axis; wrap flags the last count.
// Advances one per enabled clock; no backpressure.
module vga_axis_counter #(
  parameter int TOTAL = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       wrap
);

  assign wrap = (cnt == 10'(TOTAL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing; outputs are registered one tick behind the counters, no backpressure.
// VGA_CLK_DIV2_EN: clk is 50 MHz and a /2 toggle makes the pixel tick; else clk is the pixel clock.
module vga_timing_generator #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_timing_generator_if.master vga
);
  import vga_timing_pkg::*;

  localparam int   H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  logic tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;
  logic v_wrap;
  logic at_origin;
  logic h_vis;
  logic v_vis;

`ifdef VGA_CLK_DIV2_EN
  logic div_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  // Gated by reset so the strobe reads 0 while the block is held in reset.
  assign vga.pixel_tick = tick & rst;

  vga_axis_counter #(.TOTAL(H_TOT)) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (tick),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOT)) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap & tick),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // Tracks (h,v)==(0,0) from the wrap flags instead of a full two-axis compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      at_origin <= 1'b1;
    end else if (tick) begin
      at_origin <= h_wrap & v_wrap;
    end
  end

  assign h_vis = (h_cnt < H_VIS);
  assign v_vis = (v_cnt < V_VIS);

  // row is a plain truncation of v_cnt; safe because it is zeroed outside the visible lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.blank_n     <= 1'b0;
      vga.row         <= '0;
      vga.column      <= '0;
      vga.frame_start <= 1'b0;
    end else if (tick) begin
      vga.hsync       <= ~in_span(h_cnt, HS_START, HS_END);
      vga.vsync       <= ~in_span(v_cnt, VS_START, VS_END);
      vga.blank_n     <= h_vis & v_vis;
      vga.row         <= v_vis ? v_cnt[8:0] : '0;
      vga.column      <= h_vis ? h_cnt : '0;
      vga.frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench: full-size and reduced-geometry raster instances checked every clock against an arithmetic model.
module tb_vga_timing_generator;

`ifdef VGA_CLK_DIV2_EN
  localparam int DIVF = 2;
`else
  localparam int DIVF = 1;
`endif

  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVV = 48, SVF = 3, SVS = 2, SVB = 5;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;
  localparam logic [23:0] RST_VEC = {1'b1, 1'b1, 1'b0, 9'd0, 10'd0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   clk_n = 0;
  bit   in_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_generator_if vif_d();
  vga_timing_generator_if vif_s();

  vga_timing_generator u_dut_d (
    .clk (clk),
    .rst (rst),
    .vga (vif_d.master)
  );

  vga_timing_generator #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .vga (vif_s.master)
  );

  // Expected outputs after k clocks since reset release: tick count -> raster position -> outputs.
  function automatic logic [23:0] model(input int k, input bit r, input int hv, input int hf,
                                        input int hs, input int hb, input int vv, input int vf,
                                        input int vs, input int vb);
    int ticks, t, ht, vt, h, v;
    logic pt, bl, hsy, vsy, fs;
    logic [8:0] rw;
    logic [9:0] cl;
    if (r) return RST_VEC;
    pt = (DIVF == 2) ? (k % 2 == 1) : 1'b1;
    ticks = k / DIVF;
    if (ticks == 0) return {1'b1, 1'b1, 1'b0, 9'd0, 10'd0, pt, 1'b0};
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    t = ticks - 1;
    h = t % ht;
    v = (t / ht) % vt;
    bl = (h < hv) && (v < vv);
    cl = (h < hv) ? 10'(h) : 10'd0;
    rw = (v < vv) ? 9'(v) : 9'd0;
    hsy = !((h >= hv + hf) && (h < hv + hf + hs));
    vsy = !((v >= vv + vf) && (v < vv + vf + vs));
    fs = (h == 0) && (v == 0);
    return {hsy, vsy, bl, rw, cl, pt, fs};
  endfunction

  function automatic logic [23:0] exp_d();
    return model(clk_n, in_rst, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [23:0] exp_s();
    return model(clk_n, in_rst, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic logic [23:0] obs_d();
    return {vif_d.hsync, vif_d.vsync, vif_d.blank_n, vif_d.row, vif_d.column,
            vif_d.pixel_tick, vif_d.frame_start};
  endfunction

  function automatic logic [23:0] obs_s();
    return {vif_s.hsync, vif_s.vsync, vif_s.blank_n, vif_s.row, vif_s.column,
            vif_s.pixel_tick, vif_s.frame_start};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
    if (!in_rst) clk_n++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_rst = 1'b1;
    clk_n = 0;
    repeat (3) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL reset_hold_d got=%h exp=%h", obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL reset_hold_s got=%h exp=%h", obs_s(), exp_s()); end
    end
    rst = 1'b1;
    in_rst = 1'b0;
    clk_n = 0;
    #1;
    checks += 2;
    if (obs_d() !== exp_d()) begin failures++; $display("FAIL release_d got=%h exp=%h", obs_d(), exp_d()); end
    if (obs_s() !== exp_s()) begin failures++; $display("FAIL release_s got=%h exp=%h", obs_s(), exp_s()); end
    repeat (DIVF) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL first_clk_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL first_clk_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
    end
    checks++;
    if ({vif_d.blank_n, vif_d.row, vif_d.column, vif_d.frame_start, vif_d.hsync, vif_d.vsync}
        !== {1'b1, 9'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL first_tick got blank=%b row=%0d col=%0d fs=%b hs=%b vs=%b exp 1,0,0,1,1,1",
               vif_d.blank_n, vif_d.row, vif_d.column, vif_d.frame_start, vif_d.hsync, vif_d.vsync);
    end
  endtask

  task automatic test_first_line();
    int hs_low = 0;
    int blank_fall = -1;
    while (clk_n < 800 * DIVF) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL line_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL line_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
      if (!vif_d.hsync) hs_low++;
      if (blank_fall < 0 && !vif_d.blank_n) begin
        blank_fall = clk_n;
        checks++;
        if (vif_d.column !== 10'd0) begin failures++; $display("FAIL col_blank got=%0d exp=0", vif_d.column); end
      end
    end
    checks += 3;
    if (hs_low !== 96 * DIVF) begin failures++; $display("FAIL hsync_width got=%0d exp=%0d", hs_low, 96 * DIVF); end
    if (blank_fall !== 641 * DIVF) begin failures++; $display("FAIL blank_fall got=%0d exp=%0d", blank_fall, 641 * DIVF); end
    if (vif_d.hsync !== 1'b1) begin failures++; $display("FAIL hsync_return got=%b exp=1", vif_d.hsync); end
  endtask

  task automatic test_full_frame();
    int rises = 0;
    int r1 = 0;
    int r2 = 0;
    int vs_low = 0;
    logic [8:0] row_max = '0;
    logic prev_fs;
    prev_fs = vif_s.frame_start;
    while (clk_n < (2 * SFR + 4) * DIVF) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL frame_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL frame_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
      if (vif_s.frame_start && !prev_fs) begin
        rises++;
        if (rises == 1) r1 = clk_n;
        else if (rises == 2) r2 = clk_n;
      end
      prev_fs = vif_s.frame_start;
      if (rises == 1 && !vif_s.vsync) vs_low++;
      if (vif_s.row > row_max) row_max = vif_s.row;
    end
    checks += 4;
    if (rises !== 2) begin failures++; $display("FAIL fs_count got=%0d exp=2", rises); end
    if (r2 - r1 !== SFR * DIVF) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", r2 - r1, SFR * DIVF); end
    if (vs_low !== SVS * SHT * DIVF) begin failures++; $display("FAIL vsync_width got=%0d exp=%0d", vs_low, SVS * SHT * DIVF); end
    if (row_max !== 9'(SVV - 1)) begin failures++; $display("FAIL row_max got=%0d exp=%0d", row_max, SVV - 1); end
  endtask

  task automatic test_wrap();
    while (clk_n < 3 * SFR * DIVF) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL wrap_run_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL wrap_run_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
    end
    checks++;
    if ({vif_s.blank_n, vif_s.row, vif_s.column, vif_s.frame_start} !== {1'b0, 9'd0, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL last_pixel got blank=%b row=%0d col=%0d fs=%b exp 0,0,0,0",
               vif_s.blank_n, vif_s.row, vif_s.column, vif_s.frame_start);
    end
    repeat (DIVF) clk_step();
    checks++;
    if ({vif_s.blank_n, vif_s.row, vif_s.column, vif_s.frame_start} !== {1'b1, 9'd0, 10'd0, 1'b1}) begin
      failures++;
      $display("FAIL wrap_origin got blank=%b row=%0d col=%0d fs=%b exp 1,0,0,1",
               vif_s.blank_n, vif_s.row, vif_s.column, vif_s.frame_start);
    end
    for (int i = 0; i < (SHT - 1) * DIVF; i++) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL line0_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL line0_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
    end
    checks++;
    if (vif_s.row !== 9'd0) begin failures++; $display("FAIL line0_end row got=%0d exp=0", vif_s.row); end
    repeat (DIVF) clk_step();
    checks++;
    if ({vif_s.blank_n, vif_s.row, vif_s.column} !== {1'b1, 9'd1, 10'd0}) begin
      failures++;
      $display("FAIL line1_start got blank=%b row=%0d col=%0d exp 1,1,0", vif_s.blank_n, vif_s.row, vif_s.column);
    end
  endtask

  task automatic test_mid_reset(input int target, input int hold, input bit check_pos);
    while (clk_n < target) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL pre_rst_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL pre_rst_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
    end
    if (check_pos) begin
      checks++;
      if ({vif_s.row, vif_s.column} !== {9'd20, 10'd29}) begin
        failures++;
        $display("FAIL rst_point got row=%0d col=%0d exp 20,29", vif_s.row, vif_s.column);
      end
    end
    #3;
    rst = 1'b0;
    in_rst = 1'b1;
    #1;
    checks += 2;
    if (obs_d() !== RST_VEC) begin failures++; $display("FAIL async_rst_d got=%h exp=%h", obs_d(), RST_VEC); end
    if (obs_s() !== RST_VEC) begin failures++; $display("FAIL async_rst_s got=%h exp=%h", obs_s(), RST_VEC); end
    for (int i = 0; i < hold; i++) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL rst_hold_d got=%h exp=%h", obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL rst_hold_s got=%h exp=%h", obs_s(), exp_s()); end
    end
    rst = 1'b1;
    in_rst = 1'b0;
    clk_n = 0;
    repeat (DIVF) begin
      clk_step();
      checks += 2;
      if (obs_d() !== exp_d()) begin failures++; $display("FAIL restart_d clk=%0d got=%h exp=%h", clk_n, obs_d(), exp_d()); end
      if (obs_s() !== exp_s()) begin failures++; $display("FAIL restart_s clk=%0d got=%h exp=%h", clk_n, obs_s(), exp_s()); end
    end
    checks++;
    if ({vif_s.frame_start, vif_s.blank_n, vif_s.row, vif_s.column} !== {1'b1, 1'b1, 9'd0, 10'd0}) begin
      failures++;
      $display("FAIL restart_origin got fs=%b blank=%b row=%0d col=%0d exp 1,1,0,0",
               vif_s.frame_start, vif_s.blank_n, vif_s.row, vif_s.column);
    end
  endtask

  initial begin
    int b;
    test_reset();
    test_first_line();
    test_full_frame();
    test_wrap();
    b = ((clk_n / DIVF) / SFR) * SFR + SHT * 20 + 30;
    if (b * DIVF <= clk_n) b += SFR;
    test_mid_reset(b * DIVF, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      test_mid_reset(clk_n + int'($urandom_range(5, 2000)), int'($urandom_range(1, 4)), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
